// File: rtl/synth_pkg.sv
// Shared constants, command field positions, FSM encoding and a saturation
// helper for the voice allocator and its mixer.
package synth_pkg;

    localparam int MIDI_W = 7;
    localparam int VEL_W  = 8;
    localparam logic [MIDI_W-1:0] NOTE_NONE = 7'h7f;

    localparam int CMD_BIT = 15;
    localparam int NOTE_HI = 14;
    localparam int NOTE_LO = 8;
    localparam int VEL_HI  = 7;
    localparam int VEL_LO  = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        APPLY  = 2'd2
    } fsm_state_e;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_POS  = 2'd1,
        SAT_NEG  = 2'd2
    } sat_e;

    // Classifies a sign-extended value against the signed range of width w.
    function automatic sat_e sat_check(input logic signed [63:0] x, input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            sat_check = SAT_POS;
        end else if (x < lo) begin
            sat_check = SAT_NEG;
        end else begin
            sat_check = SAT_NONE;
        end
    endfunction

endpackage

// File: rtl/voice_mixer.sv
// Round-robin frame mixer: one voice slot per cycle, shifted and saturated
// sum emitted with a one-cycle strobe at the end of each frame.
module voice_mixer
    import synth_pkg::*;
#(
    parameter int N_VOICES  = 16,
    parameter int SAMPLE_W  = 16,
    parameter int MIX_SHIFT = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_VOICES-1:0]          gate_i,
    input  logic [SAMPLE_W*N_VOICES-1:0] samples_i,
    output logic [SAMPLE_W-1:0]          sample_o,
    output logic                         sample_valid_o
);
    localparam int IDX_W = $clog2(N_VOICES);
    localparam int ACC_W = SAMPLE_W + $clog2(N_VOICES) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

    logic [SAMPLE_W-1:0]     samp [N_VOICES];
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, term, acc_final, acc_shifted;
    logic [SAMPLE_W-1:0]     sample_q, sample_d;
    logic                    valid_q, last;
    sat_e                    sat_dir;

    for (genvar gi = 0; gi < N_VOICES; gi++) begin : g_unpack
        assign samp[gi] = samples_i[gi*SAMPLE_W +: SAMPLE_W];
    end

    always_comb begin
        last        = (idx_q == LAST_IDX);
        term        = gate_i[idx_q] ? {{(ACC_W-SAMPLE_W){samp[idx_q][SAMPLE_W-1]}}, samp[idx_q]} : '0;
        acc_final   = acc_q + term;
        acc_shifted = acc_final >>> MIX_SHIFT;
        sat_dir     = sat_check({{(64-ACC_W){acc_shifted[ACC_W-1]}}, acc_shifted}, SAMPLE_W);
        case (sat_dir)
            SAT_POS: sample_d = {1'b0, {(SAMPLE_W-1){1'b1}}};
            SAT_NEG: sample_d = {1'b1, {(SAMPLE_W-1){1'b0}}};
            default: sample_d = acc_shifted[SAMPLE_W-1:0];
        endcase
        // The next frame's first term is added on the cycle after the wrap.
        idx_d = last ? '0 : idx_q + 1'b1;
        acc_d = last ? '0 : acc_final;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q    <= '0;
            acc_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            valid_q <= last;
            if (last) begin
                sample_q <= sample_d;
            end
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;

endmodule

// File: rtl/voice_allocator.sv
// Note command handler: assigns notes to voice slots (retrigger, note-off,
// STOP_ALL, oldest-voice stealing) and feeds the frame mixer.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int N_VOICES  = 16,
    parameter int SAMPLE_W  = 16,
    parameter int MIX_SHIFT = 2,
    parameter int AGE_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [15:0]                  i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic [N_VOICES-1:0]          o_gate,
    output logic [MIDI_W*N_VOICES-1:0]   o_note,
    output logic [VEL_W*N_VOICES-1:0]    o_vel,
    output logic [N_VOICES-1:0]          o_trig,
    input  logic [SAMPLE_W*N_VOICES-1:0] i_samples,
    output logic [SAMPLE_W-1:0]          o_sample,
    output logic                         o_sample_valid
);
    localparam int IDX_W = $clog2(N_VOICES);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    fsm_state_e        state_q, state_d;
    logic [15:0]       cmd_q;
    logic [N_VOICES-1:0] gate_q, trig_q;
    logic [MIDI_W-1:0] note_q [N_VOICES];
    logic [VEL_W-1:0]  vel_q  [N_VOICES];
    logic [AGE_W-1:0]  age_q  [N_VOICES];

    logic              cmd_on;
    logic [MIDI_W-1:0] cmd_note;
    logic [VEL_W-1:0]  cmd_vel;
    logic              match_hit_d, match_hit_q, free_hit_d, free_hit_q, oldest_hit;
    logic [IDX_W-1:0]  match_idx_d, match_idx_q, free_idx_d, free_idx_q;
    logic [IDX_W-1:0]  oldest_idx_d, oldest_idx_q, target_idx;
    logic [AGE_W-1:0]  oldest_age;

    assign cmd_on   = cmd_q[CMD_BIT];
    assign cmd_note = cmd_q[NOTE_HI:NOTE_LO];
    assign cmd_vel  = cmd_q[VEL_HI:VEL_LO];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_valid) state_d = SEARCH;
            SEARCH:  state_d = APPLY;
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state_q == IDLE);
    end

    // Lowest-index wins for match/free; strict compare keeps the lowest on age ties.
    always_comb begin
        match_hit_d  = 1'b0;
        match_idx_d  = '0;
        free_hit_d   = 1'b0;
        free_idx_d   = '0;
        oldest_hit   = 1'b0;
        oldest_idx_d = '0;
        oldest_age   = '0;
        for (int i = 0; i < N_VOICES; i++) begin
            if (gate_q[i] && note_q[i] == cmd_note && !match_hit_d) begin
                match_hit_d = 1'b1;
                match_idx_d = IDX_W'(i);
            end
            if (!gate_q[i] && !free_hit_d) begin
                free_hit_d = 1'b1;
                free_idx_d = IDX_W'(i);
            end
            if (gate_q[i] && (!oldest_hit || age_q[i] > oldest_age)) begin
                oldest_hit   = 1'b1;
                oldest_idx_d = IDX_W'(i);
                oldest_age   = age_q[i];
            end
        end
        target_idx = match_hit_q ? match_idx_q : (free_hit_q ? free_idx_q : oldest_idx_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q        <= '0;
            gate_q       <= '0;
            trig_q       <= '0;
            match_hit_q  <= 1'b0;
            match_idx_q  <= '0;
            free_hit_q   <= 1'b0;
            free_idx_q   <= '0;
            oldest_idx_q <= '0;
            for (int i = 0; i < N_VOICES; i++) begin
                note_q[i] <= NOTE_NONE;
                vel_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            trig_q <= '0;
            if (o_ready && i_valid) begin
                cmd_q <= i_data;
            end
            if (state_q == SEARCH) begin
                match_hit_q  <= match_hit_d;
                match_idx_q  <= match_idx_d;
                free_hit_q   <= free_hit_d;
                free_idx_q   <= free_idx_d;
                oldest_idx_q <= oldest_idx_d;
            end
            if (state_q == APPLY) begin
                for (int i = 0; i < N_VOICES; i++) begin
                    if (cmd_on && cmd_note != NOTE_NONE) begin
                        if (IDX_W'(i) == target_idx) begin
                            gate_q[i] <= 1'b1;
                            note_q[i] <= cmd_note;
                            vel_q[i]  <= cmd_vel;
                            age_q[i]  <= '0;
                            trig_q[i] <= 1'b1;
                        end else if (gate_q[i] && age_q[i] != AGE_MAX) begin
                            age_q[i] <= age_q[i] + 1'b1;
                        end
                    end else if (!cmd_on && (cmd_note == NOTE_NONE
                                 || (match_hit_q && IDX_W'(i) == match_idx_q))) begin
                        gate_q[i] <= 1'b0;
                        note_q[i] <= NOTE_NONE;
                        vel_q[i]  <= '0;
                        age_q[i]  <= '0;
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < N_VOICES; gi++) begin : g_pack
        assign o_note[gi*MIDI_W +: MIDI_W] = note_q[gi];
        assign o_vel[gi*VEL_W +: VEL_W]    = vel_q[gi];
    end

    assign o_gate = gate_q;
    assign o_trig = trig_q;

    voice_mixer #(
        .N_VOICES  (N_VOICES),
        .SAMPLE_W  (SAMPLE_W),
        .MIX_SHIFT (MIX_SHIFT)
    ) u_mixer (
        .clk            (clk),
        .rst_n          (rst_n),
        .gate_i         (gate_q),
        .samples_i      (i_samples),
        .sample_o       (o_sample),
        .sample_valid_o (o_sample_valid)
    );

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios with literal expectations plus
// randomized commands/samples checked every cycle against a timestamp-based model.
module tb_voice_allocator;
    localparam int N    = 4;
    localparam int SW   = 16;
    localparam int SH   = 0;
    localparam int AW   = 3;
    localparam int AMAX = (1 << AW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [15:0]     i_data;
    logic            i_valid;
    logic            o_ready;
    logic [N-1:0]    o_gate, o_trig;
    logic [7*N-1:0]  o_note;
    logic [8*N-1:0]  o_vel;
    logic [SW*N-1:0] i_samples;
    logic [SW-1:0]   o_sample;
    logic            o_sample_valid;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    voice_allocator #(
        .N_VOICES  (N),
        .SAMPLE_W  (SW),
        .MIX_SHIFT (SH),
        .AGE_W     (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .o_gate         (o_gate),
        .o_note         (o_note),
        .o_vel          (o_vel),
        .o_trig         (o_trig),
        .i_samples      (i_samples),
        .o_sample       (o_sample),
        .o_sample_valid (o_sample_valid)
    );

    // Model: a voice's age is the number of note-ons since it was triggered (capped).
    bit          m_gate  [N];
    int          m_note  [N];
    int          m_vel   [N];
    int          m_stamp [N];
    bit          m_trig  [N];
    int          m_nonce;
    int          m_wait;
    logic [15:0] m_cmd;
    int          m_pos;
    longint      m_sum;
    logic [SW-1:0] m_sample;
    bit          m_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int age_of(input int k);
        int a;
        a = m_nonce - m_stamp[k];
        return (a > AMAX) ? AMAX : a;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_gate[k] = 0; m_note[k] = 127; m_vel[k] = 0; m_stamp[k] = 0; m_trig[k] = 0;
        end
        m_nonce = 0; m_wait = 0; m_cmd = '0;
        m_pos = 0; m_sum = 0; m_sample = '0; m_valid = 0;
    endtask

    task automatic apply_cmd(input logic [15:0] c);
        int note, vel, match, free, old, t;
        note = int'(c[14:8]);
        vel  = int'(c[7:0]);
        match = -1; free = -1; old = -1;
        for (int k = 0; k < N; k++) begin
            if (m_gate[k] && m_note[k] == note && match < 0) match = k;
            if (!m_gate[k] && free < 0) free = k;
            if (m_gate[k] && (old < 0 || age_of(k) > age_of(old))) old = k;
        end
        if (c[15]) begin
            if (note != 127) begin
                t = (match >= 0) ? match : ((free >= 0) ? free : old);
                m_nonce++;
                m_stamp[t] = m_nonce;
                m_gate[t] = 1; m_note[t] = note; m_vel[t] = vel; m_trig[t] = 1;
            end
        end else if (note == 127) begin
            for (int k = 0; k < N; k++) begin
                m_gate[k] = 0; m_note[k] = 127; m_vel[k] = 0;
            end
        end else if (match >= 0) begin
            m_gate[match] = 0; m_note[match] = 127; m_vel[match] = 0;
        end
    endtask

    task automatic model_step();
        logic signed [SW-1:0] sv;
        longint sh, hi, lo;
        if (!rst_n) begin
            model_reset();
        end else begin
            sv = i_samples[m_pos*SW +: SW];
            if (m_gate[m_pos]) m_sum += sv;
            m_valid = 0;
            if (m_pos == N - 1) begin
                sh = m_sum >>> SH;
                hi = (64'sd1 <<< (SW - 1)) - 1;
                lo = -(64'sd1 <<< (SW - 1));
                if (sh > hi)      m_sample = SW'(hi);
                else if (sh < lo) m_sample = SW'(lo);
                else              m_sample = SW'(sh);
                m_valid = 1; m_sum = 0; m_pos = 0;
            end else begin
                m_pos++;
            end
            for (int k = 0; k < N; k++) m_trig[k] = 0;
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) apply_cmd(m_cmd);
            end else if (i_valid) begin
                m_cmd  = i_data;
                m_wait = 2;
            end
        end
    endtask

    task automatic compare_all();
        logic [N-1:0]   eg, et;
        logic [7*N-1:0] en;
        logic [8*N-1:0] ev;
        for (int k = 0; k < N; k++) begin
            eg[k] = m_gate[k];
            et[k] = m_trig[k];
            en[k*7 +: 7] = 7'(m_note[k]);
            ev[k*8 +: 8] = 8'(m_vel[k]);
        end
        chk("model_ready", 64'(o_ready), 64'(m_wait == 0));
        chk("model_gate", 64'(o_gate), 64'(eg));
        chk("model_note", 64'(o_note), 64'(en));
        chk("model_vel", 64'(o_vel), 64'(ev));
        chk("model_trig", 64'(o_trig), 64'(et));
        chk("model_svalid", 64'(o_sample_valid), 64'(m_valid));
        chk("model_sample", 64'(o_sample), 64'(m_sample));
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        compare_all();
    end

    task automatic send(input logic [15:0] c);
        int guard;
        guard = 0;
        @(negedge clk);
        while (o_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            n_vec++; n_bad++;
            $display("FAIL ready_timeout: got o_ready=%b, expected 1 within 20 cycles", o_ready);
        end
        i_valid = 1'b1;
        i_data  = c;
        @(negedge clk);
        i_valid = 1'b0;
        i_data  = 16'($urandom);
    endtask

    // Sends and returns on the first cycle the command's effects are visible.
    task automatic send_vis(input logic [15:0] c);
        send(c);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int g;
        g = 0;
        while (o_sample_valid !== 1'b1 && g < 16) begin
            @(negedge clk);
            g++;
        end
        if (g >= 16) begin
            n_vec++; n_bad++;
            $display("FAIL %s: got no o_sample_valid, expected one within 16 cycles", name);
        end
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_samples = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_gate", 64'(o_gate), 64'd0);
        chk("rst_note", 64'(o_note), 64'({N{7'h7f}}));
        chk("rst_sample", 64'(o_sample), 64'd0);
        rst_n = 1'b1;

        // Single note-on: visible two cycles after acceptance.
        send(16'hBC40);
        chk("t1_ready_lo1", 64'(o_ready), 64'd0);
        @(negedge clk);
        chk("t1_ready_lo2", 64'(o_ready), 64'd0);
        chk("t1_gate_early", 64'(o_gate), 64'd0);
        @(negedge clk);
        chk("t1_ready_hi", 64'(o_ready), 64'd1);
        chk("t1_gate", 64'(o_gate), 64'b0001);
        chk("t1_note0", 64'(o_note[6:0]), 64'd60);
        chk("t1_vel0", 64'(o_vel[7:0]), 64'd64);
        chk("t1_trig", 64'(o_trig), 64'b0001);
        @(negedge clk);
        chk("t1_trig_clr", 64'(o_trig), 64'd0);

        // Steal the oldest voice.
        send_vis(16'hBE40);
        send_vis(16'hC040);
        send_vis(16'hC140);
        chk("t2_gate_full", 64'(o_gate), 64'b1111);
        send_vis(16'hC310);
        chk("t2_note0", 64'(o_note[6:0]), 64'd67);
        chk("t2_trig", 64'(o_trig), 64'b0001);
        chk("t2_gate", 64'(o_gate), 64'b1111);
        chk("t2_note1", 64'(o_note[13:7]), 64'd62);

        // Retrigger and note-off.
        do_reset();
        send_vis(16'hBC40);
        send_vis(16'hBC22);
        chk("t3_trig", 64'(o_trig), 64'b0001);
        chk("t3_gate", 64'(o_gate), 64'b0001);
        chk("t3_vel0", 64'(o_vel[7:0]), 64'h22);
        send_vis(16'h3C00);
        chk("t3_off_gate", 64'(o_gate), 64'd0);
        chk("t3_off_note", 64'(o_note[6:0]), 64'h7f);

        // STOP_ALL and unmatched note-off.
        send_vis(16'hBC40);
        send_vis(16'hBE40);
        send_vis(16'hC040);
        send_vis(16'h7F00);
        chk("t4_stop_gate", 64'(o_gate), 64'd0);
        chk("t4_stop_note", 64'(o_note), 64'({N{7'h7f}}));
        send_vis(16'hBD11);
        send_vis(16'h4600);
        chk("t4_unheld_gate", 64'(o_gate), 64'b0001);
        chk("t4_unheld_note", 64'(o_note[6:0]), 64'd61);

        // Mixer saturation and frame cadence.
        send_vis(16'hBC40);
        send_vis(16'hBE40);
        send_vis(16'hC040);
        chk("t5_gate", 64'(o_gate), 64'b1111);
        i_samples = {N{16'h7000}};
        wait_valid("t5_pos_a"); @(negedge clk); wait_valid("t5_pos_b");
        chk("t5_sat_pos", 64'(o_sample), 64'h7fff);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_gap", 64'(o_sample_valid), 64'd0);
        end
        @(negedge clk);
        chk("t5_period", 64'(o_sample_valid), 64'd1);
        i_samples = {N{16'h0100}};
        @(negedge clk); wait_valid("t5_mid_a"); @(negedge clk); wait_valid("t5_mid_b");
        chk("t5_sum", 64'(o_sample), 64'h0400);
        i_samples = {N{16'h9000}};
        @(negedge clk); wait_valid("t5_neg_a"); @(negedge clk); wait_valid("t5_neg_b");
        chk("t5_sat_neg", 64'(o_sample), 64'h8000);

        // Reset during SEARCH and mid-frame.
        send(16'hBC50);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_ready", 64'(o_ready), 64'd1);
        chk("t6_gate", 64'(o_gate), 64'd0);
        chk("t6_note", 64'(o_note), 64'({N{7'h7f}}));
        chk("t6_vel", 64'(o_vel), 64'd0);
        chk("t6_trig", 64'(o_trig), 64'd0);
        chk("t6_svalid", 64'(o_sample_valid), 64'd0);
        chk("t6_sample", 64'(o_sample), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t6_no_trig", 64'(o_trig), 64'd0);
        end

        // Randomized traffic; the per-cycle model comparison does the checking.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst_n   = ($urandom_range(0, 499) != 0);
            i_valid = ($urandom_range(0, 2) != 0);
            i_data[15]   = ($urandom_range(0, 3) != 0);
            i_data[14:8] = ($urandom_range(0, 6) == 0) ? 7'h7f : 7'(60 + $urandom_range(0, 5));
            i_data[7:0]  = 8'($urandom);
            for (int k = 0; k < N; k++) i_samples[k*SW +: SW] = SW'($urandom);
        end
        i_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Parametrised successor to the fixed ten-bank manager.
- Accepts 16-bit note commands over a valid/ready handshake and assigns each note to one of N_VOICES voice slots, with retrigger, note-off, STOP_ALL and oldest-voice stealing.
- Drives per-voice gate, note, velocity and retrigger to external phase_bank / waveform LUT instances.
- Scans their returned samples every frame and emits one saturated mixed sample per frame.

Parameters:
- N_VOICES, 16: number of voice slots, 2..64.
- SAMPLE_W, 16: signed width of per-voice and mixed samples.
- MIX_SHIFT, 2: arithmetic right shift applied to the frame sum before saturation.
- AGE_W, 8: per-voice age counter width; saturating.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- i_data  in  16  command: [15] 1=note-on / 0=note-off, [14:8] MIDI note, [7:0] velocity
- i_valid  in  1  command valid
- o_ready  out  1  command may be accepted this cycle
- o_gate  out  N_VOICES  voice active
- o_note  out  7*N_VOICES  note of voice k at [7k+6:7k]
- o_vel  out  8*N_VOICES  velocity of voice k
- o_trig  out  N_VOICES  one-cycle pulse; voice k must restart its phase
- i_samples  in  SAMPLE_W*N_VOICES  signed sample of voice k
- o_sample  out  SAMPLE_W  mixed signed sample
- o_sample_valid  out  1  one-cycle strobe, new o_sample

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-low (rst_n sampled on posedge clk).
  - Reset values: o_gate=0, o_note=all 7'h7f, o_vel=0, o_trig=0, o_sample=0, o_sample_valid=0, o_ready=1.
  - All ages=0, scan index=0, accumulator=0, FSM=IDLE.
  - Reset mid-command or mid-frame aborts both; no partial strobe.
- Command FSM:
  - IDLE: o_ready=1. On i_valid&&o_ready, latch i_data and go to SEARCH.
  - SEARCH: o_ready=0. Compute three results:
    - match = lowest gated voice whose note equals the cmd note.
    - free = lowest ungated voice.
    - oldest = gated voice with max age, tie goes to lowest index.
  - APPLY: o_ready=0. Update voice state and pulse o_trig, then go to IDLE.
  - Effects become visible 2 cycles after acceptance. Sustained throughput is 1 command per 3 cycles.
- APPLY rules:
  - Note-on, note 7f: reserved, ignored (no state change).
  - Note-on with match: keep the voice, update vel, age=0, pulse trig.
  - Note-on otherwise: take free, or oldest if none is free. Set gate=1, note, vel, age=0, pulse trig.
  - Every note-on that changes state increments all other gated voices' ages, saturating at 2^AGE_W-1.
  - Note-off, note 7f (STOP_ALL): all gate=0, note=7f, vel=0.
  - Note-off with match: that voice gate=0, note=7f, vel=0.
  - Note-off with no match: ignored.
  - Velocity 0 on note-on is a valid note; no implicit note-off.
- Mixer (runs continuously, independent of the FSM):
  - The scan index k runs 0..N_VOICES-1 and wraps.
  - Each cycle: acc += gate[k] ? sext(i_samples[k]) : 0. acc width is SAMPLE_W+clog2(N_VOICES)+1.
  - On k=N_VOICES-1:
    - o_sample <= sat(acc_final >>> MIX_SHIFT) to [-2^(SW-1), 2^(SW-1)-1].
    - o_sample_valid pulses.
    - acc restarts with the next frame's first term.
  - One frame = N_VOICES cycles. Gates are sampled per cycle, so a gate change mid-frame affects only the remaining slots.
  - i_samples are registered upstream; the LUT latency is absorbed by the caller.

Decomposition:
- Shared package synth_pkg:
  - MIDI_W=7, VEL_W=8, NOTE_NONE=7'h7f.
  - Command bit positions CMD_BIT=15, NOTE_HI/LO, VEL_HI/LO.
  - FSM state encoding IDLE/SEARCH/APPLY.
  - Saturation function.
- One natural sub-module: voice_mixer (scan index, accumulator, shift/saturate, strobe). The FSM and voice table stay in voice_allocator.

Test Plan:
1. Reset, then note-on 0x8A3C40 pattern (i_data=16'hBC40: note 60, vel 64) -> 2 cycles later o_gate[0]=1, o_note[0]=60, o_vel[0]=64, o_trig[0] pulses once; o_ready low for exactly 2 cycles.
2. N_VOICES=4: note-on 60,62,64,65, then note-on 67 -> voice 0 (age max) stolen: o_note[0]=67, o_trig[0]=1, gates 4'b1111.
3. Note-on 60 twice -> only voice 0 used, second pulses o_trig[0], o_gate=…0001; note-off 60 (16'h3C00) -> o_gate[0]=0, o_note[0]=7f.
4. Three voices active then i_data=16'h7F00 -> o_gate=0, all notes 7f; note-off for an unheld note 70 -> no change.
5. N=4, MIX_SHIFT=0, voices 0..3 gated, all samples 16'h7000 -> o_sample=16'h7FFF (saturate); all 16'h9000 -> 16'h8000; o_sample_valid every 4th cycle.
6. Assert rst_n=0 in SEARCH and mid-frame -> next cycle all outputs at reset values, no o_trig, no o_sample_valid.
